// File: rtl/hash_corner_fetch_if.sv
// hash_corner_fetch_if
//   Bundles the request, table-write, feature-result and SRAM request/return
//   signals of hash_corner_fetch.
//   slave  : view of the fetch block (takes requests, drives the SRAM port)
//   master : view of the surrounding logic (issues requests, models the SRAM)
interface hash_corner_fetch_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int ENCODE_WIDTH = 12,
    parameter int COORD_WIDTH  = ENCODE_WIDTH / 3
);
    // base-coordinate request
    logic                    req_valid;
    logic                    req_ready;
    logic [COORD_WIDTH-1:0]  req_x;
    logic [COORD_WIDTH-1:0]  req_y;
    logic [COORD_WIDTH-1:0]  req_z;
    // table-load write
    logic                    wr_valid;
    logic                    wr_ready;
    logic [ENCODE_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    // packed corner features
    logic                    out_valid;
    logic                    out_ready;
    logic [8*DATA_WIDTH-1:0] out_feat;
    logic                    busy;
    // SRAM request / return
    logic                    sram_2_CEN;
    logic [ENCODE_WIDTH-1:0] sram_2_A;
    logic [DATA_WIDTH-1:0]   sram_2_D;
    logic                    sram_2_GWEN;
    logic [DATA_WIDTH-1:0]   sram_2_Q;

    modport slave (
        input  req_valid, req_x, req_y, req_z,
        output req_ready,
        input  wr_valid, wr_addr, wr_data,
        output wr_ready,
        output out_valid, out_feat, busy,
        input  out_ready,
        output sram_2_CEN, sram_2_A, sram_2_D, sram_2_GWEN,
        input  sram_2_Q
    );

    modport master (
        output req_valid, req_x, req_y, req_z,
        input  req_ready,
        output wr_valid, wr_addr, wr_data,
        input  wr_ready,
        input  out_valid, out_feat, busy,
        output out_ready,
        input  sram_2_CEN, sram_2_A, sram_2_D, sram_2_GWEN,
        output sram_2_Q
    );
endinterface

// File: rtl/hash_corner_fetch.sv
// hash_corner_fetch
//   Takes one voxel base coordinate per transaction, issues the eight
//   trilinear-corner reads (corner c = {dz,dy,dx}) one per cycle, collects the
//   returned words after the fixed read latency and presents them packed as
//   out_feat[c*DATA_WIDTH +: DATA_WIDTH]. In IDLE it also forwards single-beat
//   table-load writes to the SRAM port.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : hash_corner_fetch_if.slave (request / write / result / SRAM)
module hash_corner_fetch #(
    parameter int DATA_WIDTH   = 8,
    parameter int ENCODE_WIDTH = 12,
    parameter int COORD_WIDTH  = ENCODE_WIDTH / 3,
    parameter int RD_LATENCY   = 3
) (
    input logic                clk,
    input logic                rst,
    hash_corner_fetch_if.slave bus
);
    localparam int FW = 8 * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;        // next corner to issue; 8 = all issued
    logic [COORD_WIDTH-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
    logic                    cen_q, cen_d;
    logic                    gwen_q, gwen_d;
    logic [ENCODE_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0]   d_q, d_d;
    logic [2:0]              corner_q, corner_d;  // corner index of the read on the port
    logic                    out_valid_q, out_valid_d;
    logic [FW-1:0]           out_feat_q, out_feat_d;
    logic [RD_LATENCY-1:0]       tag_vld_q, tag_vld_d;
    logic [RD_LATENCY-1:0][2:0]  tag_idx_q, tag_idx_d;

    logic       rd_on_port;
    logic       cap_vld;
    logic [2:0] cap_idx;

    // Address of corner c relative to base (x,y,z); each axis wraps silently.
    function automatic logic [ENCODE_WIDTH-1:0] corner_addr(
        input logic [2:0]             c,
        input logic [COORD_WIDTH-1:0] bx,
        input logic [COORD_WIDTH-1:0] by,
        input logic [COORD_WIDTH-1:0] bz
    );
        logic [COORD_WIDTH-1:0] ax, ay, az;
        ax = bx + COORD_WIDTH'(c[0]);
        ay = by + COORD_WIDTH'(c[1]);
        az = bz + COORD_WIDTH'(c[2]);
        return {az, ay, ax};
    endfunction

    // The tag enters the pipe from the registered request, so it lines up
    // with the SRAM's own input register: after RD_LATENCY more edges the
    // tag and the matching sram_2_Q are both valid in the same cycle.
    assign rd_on_port = !cen_q && gwen_q;
    assign cap_vld    = tag_vld_q[RD_LATENCY-1];
    assign cap_idx    = tag_idx_q[RD_LATENCY-1];

    always_comb begin
        tag_vld_d    = tag_vld_q;
        tag_idx_d    = tag_idx_q;
        tag_vld_d[0] = rd_on_port;
        tag_idx_d[0] = corner_q;
        for (int i = 1; i < RD_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_idx_d[i] = tag_idx_q[i-1];
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            cen_q       <= 1'b1;
            gwen_q      <= 1'b1;
            a_q         <= '0;
            d_q         <= '0;
            corner_q    <= '0;
            out_valid_q <= 1'b0;
            out_feat_q  <= '0;
            tag_vld_q   <= '0;
            tag_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            cen_q       <= cen_d;
            gwen_q      <= gwen_d;
            a_q         <= a_d;
            d_q         <= d_d;
            corner_q    <= corner_d;
            out_valid_q <= out_valid_d;
            out_feat_q  <= out_feat_d;
            tag_vld_q   <= tag_vld_d;
            tag_idx_q   <= tag_idx_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid)                state_d = ISSUE;
            ISSUE:   if (cnt_q == 4'd8)                state_d = DRAIN;
            DRAIN:   if (cap_vld && cap_idx == 3'd7)   state_d = DONE;
            DONE:    if (bus.out_ready)                state_d = IDLE;
            default:                                   state_d = IDLE;
        endcase
    end

    // ---------------- outputs / datapath ----------------
    always_comb begin
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        cen_d       = 1'b1;
        gwen_d      = 1'b1;
        a_d         = a_q;
        d_d         = d_q;      // held through reads
        corner_d    = corner_q;
        out_valid_d = out_valid_q;
        out_feat_d  = out_feat_q;

        if (cap_vld)
            out_feat_d[int'(cap_idx)*DATA_WIDTH +: DATA_WIDTH] = bus.sram_2_Q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    x_d      = bus.req_x;
                    y_d      = bus.req_y;
                    z_d      = bus.req_z;
                    cen_d    = 1'b0;
                    a_d      = corner_addr(3'd0, bus.req_x, bus.req_y, bus.req_z);
                    corner_d = 3'd0;
                    cnt_d    = 4'd1;
                end else if (bus.wr_valid) begin
                    cen_d  = 1'b0;
                    gwen_d = 1'b0;
                    a_d    = bus.wr_addr;
                    d_d    = bus.wr_data;
                end
            end
            ISSUE: begin
                if (cnt_q != 4'd8) begin
                    cen_d    = 1'b0;
                    a_d      = corner_addr(cnt_q[2:0], x_q, y_q, z_q);
                    corner_d = cnt_q[2:0];
                    cnt_d    = cnt_q + 4'd1;
                end
            end
            DRAIN: begin
                if (cap_vld && cap_idx == 3'd7)
                    out_valid_d = 1'b1;
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_d       = '0;
                end
            end
            default: ;
        endcase
    end

    assign bus.req_ready   = (state_q == IDLE);
    assign bus.wr_ready    = (state_q == IDLE) && !bus.req_valid;
    assign bus.busy        = (state_q != IDLE);
    assign bus.out_valid   = out_valid_q;
    assign bus.out_feat    = out_feat_q;
    assign bus.sram_2_CEN  = cen_q;
    assign bus.sram_2_GWEN = gwen_q;
    assign bus.sram_2_A    = a_q;
    assign bus.sram_2_D    = d_q;
endmodule

// File: tb/tb_hash_corner_fetch.sv
module tb_hash_corner_fetch;
    localparam int RDL = 3;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    hash_corner_fetch_if #(.DATA_WIDTH(8), .ENCODE_WIDTH(12), .COORD_WIDTH(4)) bus ();

    hash_corner_fetch #(.DATA_WIDTH(8), .ENCODE_WIDTH(12), .COORD_WIDTH(4), .RD_LATENCY(RDL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: samples the request on the edge after it appears, data is
    // on Q RD_LATENCY cycles after the request was visible.
    logic [7:0] mem [4096];
    logic [7:0] rpipe [RDL];
    always @(posedge clk) begin
        if (!bus.sram_2_CEN && !bus.sram_2_GWEN)
            mem[bus.sram_2_A] <= bus.sram_2_D;
        rpipe[0] <= mem[bus.sram_2_A];
        for (int i = 1; i < RDL; i++) rpipe[i] <= rpipe[i-1];
    end
    assign bus.sram_2_Q = rpipe[RDL-1];

    typedef struct {
        logic [3:0]  x, y, z;
        logic [63:0] feat;
        logic [11:0] a0, a7;
    } vec_t;
    vec_t vecs [4];

    logic [11:0] addrs [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic rec();
        if (!bus.sram_2_CEN && bus.sram_2_GWEN) addrs.push_back(bus.sram_2_A);
    endtask

    // Present a request, wait (bounded) for out_valid. Returns after the edge
    // that raised out_valid; lat counts edges after the acceptance edge.
    task automatic run_req(input logic [3:0] x, input logic [3:0] y, input logic [3:0] z,
                           output logic [63:0] feat, output int lat);
        bus.req_x = x; bus.req_y = y; bus.req_z = z;
        bus.req_valid = 1'b1;
        #1;
        chk("req_ready", bus.req_ready, 1);
        step();
        bus.req_valid = 1'b0;
        addrs.delete();
        rec();
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            step();
            lat++;
            rec();
        end
        feat = bus.out_feat;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cen"},  bus.sram_2_CEN, 1);
        chk({tag, "_a"},    bus.sram_2_A, 0);
        chk({tag, "_d"},    bus.sram_2_D, 0);
        chk({tag, "_gwen"}, bus.sram_2_GWEN, 1);
        chk({tag, "_ov"},   bus.out_valid, 0);
        chk({tag, "_feat"}, bus.out_feat, 0);
        chk({tag, "_busy"}, bus.busy, 0);
    endtask

    initial begin
        logic [63:0] feat, saved;
        logic [11:0] wrap_exp [8];
        int lat, errs, nwr;

        // low byte of {z',y',x'} is {y',x'}
        vecs[0] = '{x:4'd2,  y:4'd3,  z:4'd4,  feat:64'h4342333243423332, a0:12'h432, a7:12'h543};
        vecs[1] = '{x:4'd15, y:4'd15, z:4'd15, feat:64'h000FF0FF000FF0FF, a0:12'hFFF, a7:12'h000};
        vecs[2] = '{x:4'd0,  y:4'd0,  z:4'd0,  feat:64'h1110010011100100, a0:12'h000, a7:12'h111};
        vecs[3] = '{x:4'd7,  y:4'd8,  z:4'd9,  feat:64'h9897888798978887, a0:12'h987, a7:12'hA98};
        wrap_exp = '{12'hFFF, 12'hFF0, 12'hF0F, 12'hF00, 12'h0FF, 12'h0F0, 12'h00F, 12'h000};

        rst = 1'b1;
        bus.req_valid = 0; bus.req_x = 0; bus.req_y = 0; bus.req_z = 0;
        bus.wr_valid = 0; bus.wr_addr = 0; bus.wr_data = 0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst0");
        chk("rst0_req_ready", bus.req_ready, 1);
        chk("rst0_wr_ready", bus.wr_ready, 1);
        rst = 1'b0;
        step();

        // table load: mem[a] = a[7:0]
        for (int a = 0; a < 4096; a++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 12'(a);
            bus.wr_data  = 8'(a);
            step();
            if (a == 5) begin
                chk("wr_cen", bus.sram_2_CEN, 0);
                chk("wr_gwen", bus.sram_2_GWEN, 0);
                chk("wr_a", bus.sram_2_A, 12'h005);
                chk("wr_d", bus.sram_2_D, 8'h05);
            end
        end
        bus.wr_valid = 1'b0;
        step();

        // table-driven reads
        for (int i = 0; i < 4; i++) begin
            run_req(vecs[i].x, vecs[i].y, vecs[i].z, feat, lat);
            chk($sformatf("v%0d_lat", i), lat, 11);
            chk($sformatf("v%0d_feat", i), feat, vecs[i].feat);
            chk($sformatf("v%0d_nrd", i), addrs.size(), 8);
            if (addrs.size() == 8) begin
                chk($sformatf("v%0d_a0", i), addrs[0], vecs[i].a0);
                chk($sformatf("v%0d_a7", i), addrs[7], vecs[i].a7);
            end
            step();
            chk($sformatf("v%0d_exit_ov", i), bus.out_valid, 0);
            chk($sformatf("v%0d_exit_busy", i), bus.busy, 0);
        end

        // wrap-around: full issue order
        run_req(4'd15, 4'd15, 4'd15, feat, lat);
        chk("wrap_nrd", addrs.size(), 8);
        if (addrs.size() == 8)
            for (int k = 0; k < 8; k++) chk($sformatf("wrap_a%0d", k), addrs[k], wrap_exp[k]);
        step();

        // backpressure: stall 20 cycles in DONE
        bus.out_ready = 1'b0;
        run_req(4'd2, 4'd3, 4'd4, saved, lat);
        chk("bp_feat", saved, 64'h4342333243423332);
        errs = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus.out_valid !== 1'b1 || bus.out_feat !== saved || bus.req_ready !== 1'b0 ||
                bus.sram_2_CEN !== 1'b1 || bus.busy !== 1'b1)
                errs++;
        end
        chk("bp_stall", errs, 0);
        bus.out_ready = 1'b1;
        step();
        chk("bp_exit_ov", bus.out_valid, 0);
        chk("bp_exit_rdy", bus.req_ready, 1);

        // simultaneous request and write: read wins, write waits for IDLE
        bus.req_x = 4'd2; bus.req_y = 4'd3; bus.req_z = 4'd4;
        bus.req_valid = 1'b1;
        bus.wr_valid = 1'b1; bus.wr_addr = 12'h555; bus.wr_data = 8'h3C;
        #1;
        chk("sim_wr_ready", bus.wr_ready, 0);
        chk("sim_req_ready", bus.req_ready, 1);
        step();
        bus.req_valid = 1'b0;
        chk("sim_rd_gwen", bus.sram_2_GWEN, 1);
        chk("sim_rd_a", bus.sram_2_A, 12'h432);
        nwr = 0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            step();
            lat++;
            if (!bus.sram_2_CEN && !bus.sram_2_GWEN) nwr++;
        end
        chk("sim_lat", lat, 11);
        chk("sim_no_early_wr", nwr, 0);
        step();
        chk("sim_exit_cen", bus.sram_2_CEN, 1);
        chk("sim_idle_wr_ready", bus.wr_ready, 1);
        step();
        chk("sim_wr_cen", bus.sram_2_CEN, 0);
        chk("sim_wr_gwen", bus.sram_2_GWEN, 0);
        chk("sim_wr_a", bus.sram_2_A, 12'h555);
        chk("sim_wr_d", bus.sram_2_D, 8'h3C);
        bus.wr_valid = 1'b0;
        step();

        // read-after-write
        bus.wr_valid = 1'b1; bus.wr_addr = 12'h234; bus.wr_data = 8'hA5;
        step();
        bus.wr_valid = 1'b0;
        run_req(4'd4, 4'd3, 4'd2, feat, lat);
        chk("raw_c0", feat[7:0], 8'hA5);
        chk("raw_c1", feat[15:8], 8'h35);
        step();

        // reset in the middle of ISSUE
        bus.req_x = 4'd7; bus.req_y = 4'd8; bus.req_z = 4'd9;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        repeat (3) step();
        chk("mid_c3_a", bus.sram_2_A, 12'h998);
        rst = 1'b1;
        #1;
        chk_reset_vals("mid_rst");
        step();
        step();
        rst = 1'b0;
        errs = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (bus.out_valid !== 1'b0 || bus.out_feat !== 64'h0 || bus.busy !== 1'b0) errs++;
        end
        chk("mid_no_stale", errs, 0);
        run_req(4'd0, 4'd0, 4'd0, feat, lat);
        chk("post_rst_lat", lat, 11);
        chk("post_rst_feat", feat, 64'h1110010011100100);
        step();
        chk("post_rst_exit", bus.out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
